// File: rtl/bls12_381_fe2_mul_stream.sv
// rtl/bls12_381_fe2_mul_stream.sv - Fp2 multiply sequencer driving external Fp mul/add/sub units
module bls12_381_fe2_mul_stream #(
    parameter type FE_TYPE     = logic [380:0],
    parameter int  CTL_BITS    = 16,
    parameter int  OVR_WRT_BIT = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    // Fe2 operand requests: beat k carries dat = {b[k], a[k]}
    input  logic [2*$bits(FE_TYPE)-1:0] i_mul_fe2_if_dat,
    input  logic                        i_mul_fe2_if_val,
    input  logic                        i_mul_fe2_if_sop,
    input  logic                        i_mul_fe2_if_eop,
    input  logic                        i_mul_fe2_if_err,
    input  logic [CTL_BITS-1:0]         i_mul_fe2_if_ctl,
    output logic                        i_mul_fe2_if_rdy,
    // Fe2 products: c0 then c1, one Fp element per beat
    output logic [2*$bits(FE_TYPE)-1:0] o_mul_fe2_if_dat,
    output logic                        o_mul_fe2_if_val,
    output logic                        o_mul_fe2_if_sop,
    output logic                        o_mul_fe2_if_eop,
    output logic                        o_mul_fe2_if_err,
    output logic [CTL_BITS-1:0]         o_mul_fe2_if_ctl,
    input  logic                        o_mul_fe2_if_rdy,
    // External Fp multiplier requests, dat = {b, a}
    output logic [2*$bits(FE_TYPE)-1:0] o_mul_fe_if_dat,
    output logic                        o_mul_fe_if_val,
    output logic                        o_mul_fe_if_sop,
    output logic                        o_mul_fe_if_eop,
    output logic                        o_mul_fe_if_err,
    output logic [CTL_BITS-1:0]         o_mul_fe_if_ctl,
    input  logic                        o_mul_fe_if_rdy,
    // External Fp multiplier results
    input  logic [$bits(FE_TYPE)-1:0]   i_mul_fe_if_dat,
    input  logic                        i_mul_fe_if_val,
    input  logic                        i_mul_fe_if_sop,
    input  logic                        i_mul_fe_if_eop,
    input  logic                        i_mul_fe_if_err,
    input  logic [CTL_BITS-1:0]         i_mul_fe_if_ctl,
    output logic                        i_mul_fe_if_rdy,
    // External Fp adder requests, dat = {b, a}
    output logic [2*$bits(FE_TYPE)-1:0] o_add_fe_if_dat,
    output logic                        o_add_fe_if_val,
    output logic                        o_add_fe_if_sop,
    output logic                        o_add_fe_if_eop,
    output logic                        o_add_fe_if_err,
    output logic [CTL_BITS-1:0]         o_add_fe_if_ctl,
    input  logic                        o_add_fe_if_rdy,
    // External Fp adder results
    input  logic [$bits(FE_TYPE)-1:0]   i_add_fe_if_dat,
    input  logic                        i_add_fe_if_val,
    input  logic                        i_add_fe_if_sop,
    input  logic                        i_add_fe_if_eop,
    input  logic                        i_add_fe_if_err,
    input  logic [CTL_BITS-1:0]         i_add_fe_if_ctl,
    output logic                        i_add_fe_if_rdy,
    // External Fp subtractor requests, result = a - b, dat = {b, a}
    output logic [2*$bits(FE_TYPE)-1:0] o_sub_fe_if_dat,
    output logic                        o_sub_fe_if_val,
    output logic                        o_sub_fe_if_sop,
    output logic                        o_sub_fe_if_eop,
    output logic                        o_sub_fe_if_err,
    output logic [CTL_BITS-1:0]         o_sub_fe_if_ctl,
    input  logic                        o_sub_fe_if_rdy,
    // External Fp subtractor results
    input  logic [$bits(FE_TYPE)-1:0]   i_sub_fe_if_dat,
    input  logic                        i_sub_fe_if_val,
    input  logic                        i_sub_fe_if_sop,
    input  logic                        i_sub_fe_if_eop,
    input  logic                        i_sub_fe_if_err,
    input  logic [CTL_BITS-1:0]         i_sub_fe_if_ctl,
    output logic                        i_sub_fe_if_rdy
);

    localparam int FE_BITS = $bits(FE_TYPE);

    typedef enum logic [2:0] {IDLE, LOAD1, MUL, ADDSUB, OUT} state_t;

    state_t state, state_nxt;

    // Operands and intermediate products; tags 0..3 = a0*b0, a1*b1, a0*b1, a1*b0
    logic [FE_BITS-1:0]  a0, a1, b0, b1;
    logic [FE_BITS-1:0]  t [4];
    logic [FE_BITS-1:0]  c0_r, c1_r;
    logic [CTL_BITS-1:0] ctl_r;
    logic [3:0]          mask;
    logic [2:0]          issue_cnt;
    logic                sub_sent, add_sent, got_sub, got_add;
    logic                beat;
    logic                err_r;
    // Set by reset: results from an abandoned operation are dropped quietly until the next sop
    logic                stale;

    logic       in_fire, mul_req_fire, sub_req_fire, add_req_fire, out_fire;
    logic [1:0] mul_tag;
    logic [3:0] mul_tag_bit;
    logic       mul_res_ok, mul_res_bad, sub_res_ok, sub_res_bad, add_res_ok, add_res_bad;
    logic       mul_all, addsub_all;

    // Sideband bits the block has no use for
    logic unused_inputs;
    assign unused_inputs = ^{i_mul_fe2_if_err, i_mul_fe_if_sop, i_mul_fe_if_eop, i_mul_fe_if_err,
                             i_mul_fe_if_ctl, i_add_fe_if_sop, i_add_fe_if_eop, i_add_fe_if_err,
                             i_add_fe_if_ctl, i_sub_fe_if_sop, i_sub_fe_if_eop, i_sub_fe_if_err,
                             i_sub_fe_if_ctl};

    // Replace the internal tag field of the stored ctl
    function automatic logic [CTL_BITS-1:0] tag_ctl(input logic [CTL_BITS-1:0] base,
                                                    input logic [1:0] tag);
        logic [CTL_BITS-1:0] c;
        c = base;
        c[OVR_WRT_BIT +: 2] = tag;
        return c;
    endfunction

    // Handshake and result-routing decode
    always_comb begin
        in_fire      = i_mul_fe2_if_val && i_mul_fe2_if_rdy;
        mul_req_fire = o_mul_fe_if_val && o_mul_fe_if_rdy;
        sub_req_fire = o_sub_fe_if_val && o_sub_fe_if_rdy;
        add_req_fire = o_add_fe_if_val && o_add_fe_if_rdy;
        out_fire     = o_mul_fe2_if_val && o_mul_fe2_if_rdy;
        mul_tag      = i_mul_fe_if_ctl[OVR_WRT_BIT +: 2];
        mul_tag_bit  = 4'b0001 << mul_tag;
        mul_res_ok   = !i_rst && i_mul_fe_if_val && (state == MUL) && ((mask & mul_tag_bit) == 4'b0000);
        mul_res_bad  = !i_rst && i_mul_fe_if_val && !mul_res_ok && !stale;
        sub_res_ok   = !i_rst && i_sub_fe_if_val && (state == ADDSUB) && !got_sub;
        sub_res_bad  = !i_rst && i_sub_fe_if_val && !sub_res_ok && !stale;
        add_res_ok   = !i_rst && i_add_fe_if_val && (state == ADDSUB) && !got_add;
        add_res_bad  = !i_rst && i_add_fe_if_val && !add_res_ok && !stale;
        mul_all      = &(mask | (mul_res_ok ? mul_tag_bit : 4'b0000));
        addsub_all   = (got_sub || sub_res_ok) && (got_add || add_res_ok);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire && i_mul_fe2_if_sop) state_nxt = LOAD1;
            LOAD1:   if (in_fire) state_nxt = MUL;
            MUL:     if (mul_all) state_nxt = ADDSUB;
            ADDSUB:  if (addsub_all) state_nxt = OUT;
            OUT:     if (out_fire && beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; every output is forced to zero while reset is held
    always_comb begin
        i_mul_fe2_if_rdy = 1'b0;
        o_mul_fe2_if_dat = '0;
        o_mul_fe2_if_val = 1'b0;
        o_mul_fe2_if_sop = 1'b0;
        o_mul_fe2_if_eop = 1'b0;
        o_mul_fe2_if_err = 1'b0;
        o_mul_fe2_if_ctl = '0;
        o_mul_fe_if_dat  = '0;
        o_mul_fe_if_val  = 1'b0;
        o_mul_fe_if_sop  = 1'b0;
        o_mul_fe_if_eop  = 1'b0;
        o_mul_fe_if_err  = 1'b0;
        o_mul_fe_if_ctl  = '0;
        o_add_fe_if_dat  = '0;
        o_add_fe_if_val  = 1'b0;
        o_add_fe_if_sop  = 1'b0;
        o_add_fe_if_eop  = 1'b0;
        o_add_fe_if_err  = 1'b0;
        o_add_fe_if_ctl  = '0;
        o_sub_fe_if_dat  = '0;
        o_sub_fe_if_val  = 1'b0;
        o_sub_fe_if_sop  = 1'b0;
        o_sub_fe_if_eop  = 1'b0;
        o_sub_fe_if_err  = 1'b0;
        o_sub_fe_if_ctl  = '0;
        i_mul_fe_if_rdy  = !i_rst;
        i_add_fe_if_rdy  = !i_rst;
        i_sub_fe_if_rdy  = !i_rst;
        if (!i_rst) begin
            case (state)
                IDLE, LOAD1: i_mul_fe2_if_rdy = 1'b1;
                MUL: begin
                    o_mul_fe_if_val = !issue_cnt[2];
                    o_mul_fe_if_sop = !issue_cnt[2];
                    o_mul_fe_if_eop = !issue_cnt[2];
                    o_mul_fe_if_ctl = tag_ctl(ctl_r, issue_cnt[1:0]);
                    case (issue_cnt[1:0])
                        2'd0:    o_mul_fe_if_dat = {b0, a0};
                        2'd1:    o_mul_fe_if_dat = {b1, a1};
                        2'd2:    o_mul_fe_if_dat = {b1, a0};
                        default: o_mul_fe_if_dat = {b0, a1};
                    endcase
                end
                ADDSUB: begin
                    o_sub_fe_if_val = !sub_sent;
                    o_sub_fe_if_sop = !sub_sent;
                    o_sub_fe_if_eop = !sub_sent;
                    o_sub_fe_if_dat = {t[1], t[0]};
                    o_sub_fe_if_ctl = tag_ctl(ctl_r, 2'd0);
                    o_add_fe_if_val = !add_sent;
                    o_add_fe_if_sop = !add_sent;
                    o_add_fe_if_eop = !add_sent;
                    o_add_fe_if_dat = {t[3], t[2]};
                    o_add_fe_if_ctl = tag_ctl(ctl_r, 2'd1);
                end
                OUT: begin
                    o_mul_fe2_if_val = 1'b1;
                    o_mul_fe2_if_sop = !beat;
                    o_mul_fe2_if_eop = beat;
                    o_mul_fe2_if_err = err_r;
                    o_mul_fe2_if_ctl = ctl_r;
                    o_mul_fe2_if_dat = {{FE_BITS{1'b0}}, (beat ? c1_r : c0_r)};
                end
                default: i_mul_fe2_if_rdy = 1'b0;
            endcase
        end
    end

    // Operand capture, result routing, issue bookkeeping and the sticky error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a0        <= '0;
            a1        <= '0;
            b0        <= '0;
            b1        <= '0;
            t[0]      <= '0;
            t[1]      <= '0;
            t[2]      <= '0;
            t[3]      <= '0;
            c0_r      <= '0;
            c1_r      <= '0;
            ctl_r     <= '0;
            mask      <= 4'b0000;
            issue_cnt <= 3'd0;
            sub_sent  <= 1'b0;
            add_sent  <= 1'b0;
            got_sub   <= 1'b0;
            got_add   <= 1'b0;
            beat      <= 1'b0;
            err_r     <= 1'b0;
            stale     <= 1'b1;
        end else begin
            if (in_fire && state == IDLE) begin
                if (i_mul_fe2_if_sop) begin
                    a0        <= i_mul_fe2_if_dat[0 +: FE_BITS];
                    b0        <= i_mul_fe2_if_dat[FE_BITS +: FE_BITS];
                    ctl_r     <= i_mul_fe2_if_ctl;
                    mask      <= 4'b0000;
                    issue_cnt <= 3'd0;
                    sub_sent  <= 1'b0;
                    add_sent  <= 1'b0;
                    got_sub   <= 1'b0;
                    got_add   <= 1'b0;
                    beat      <= 1'b0;
                    stale     <= 1'b0;
                end else begin
                    err_r <= 1'b1;
                end
            end
            if (in_fire && state == LOAD1) begin
                a1 <= i_mul_fe2_if_dat[0 +: FE_BITS];
                b1 <= i_mul_fe2_if_dat[FE_BITS +: FE_BITS];
                if (!i_mul_fe2_if_eop) begin
                    err_r <= 1'b1;
                end
            end
            if (mul_req_fire) begin
                issue_cnt <= issue_cnt + 3'd1;
            end
            if (mul_res_ok) begin
                t[mul_tag] <= i_mul_fe_if_dat;
                mask       <= mask | mul_tag_bit;
            end
            if (sub_req_fire) begin
                sub_sent <= 1'b1;
            end
            if (add_req_fire) begin
                add_sent <= 1'b1;
            end
            if (sub_res_ok) begin
                c0_r    <= i_sub_fe_if_dat;
                got_sub <= 1'b1;
            end
            if (add_res_ok) begin
                c1_r    <= i_add_fe_if_dat;
                got_add <= 1'b1;
            end
            if (mul_res_bad || sub_res_bad || add_res_bad) begin
                err_r <= 1'b1;
            end
            if (out_fire) begin
                beat <= ~beat;
            end
        end
    end

endmodule

// File: tb/tb_bls12_381_fe2_mul_stream.sv
// tb/tb_bls12_381_fe2_mul_stream.sv - self-checking bench with mock Fp units and Fp2 reference model
module tb_bls12_381_fe2_mul_stream;

    localparam int F   = 381;
    localparam int C   = 16;
    localparam int OVR = 8;

    typedef logic [F-1:0] fe_t;
    localparam fe_t P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    typedef struct { logic [2*F-1:0] dat; logic sop; logic eop; logic [C-1:0] ctl; } beat_t;
    typedef struct { fe_t dat; logic sop; logic eop; logic err; logic [C-1:0] ctl; } exp_t;
    typedef struct { fe_t res; logic [C-1:0] ctl; int rdy_cyc; } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*F-1:0] in_dat;  logic in_val, in_sop, in_eop, in_err, in_rdy;  logic [C-1:0] in_ctl;
    logic [2*F-1:0] out_dat; logic out_val, out_sop, out_eop, out_err, out_rdy; logic [C-1:0] out_ctl;
    logic [2*F-1:0] mq_dat;  logic mq_val, mq_sop, mq_eop, mq_err, mq_rdy;  logic [C-1:0] mq_ctl;
    logic [F-1:0]   mr_dat;  logic mr_val, mr_rdy;  logic [C-1:0] mr_ctl;
    logic [2*F-1:0] aq_dat;  logic aq_val, aq_sop, aq_eop, aq_err, aq_rdy;  logic [C-1:0] aq_ctl;
    logic [F-1:0]   ar_dat;  logic ar_val, ar_rdy;  logic [C-1:0] ar_ctl;
    logic [2*F-1:0] sq_dat;  logic sq_val, sq_sop, sq_eop, sq_err, sq_rdy;  logic [C-1:0] sq_ctl;
    logic [F-1:0]   sr_dat;  logic sr_val, sr_rdy;  logic [C-1:0] sr_ctl;

    bls12_381_fe2_mul_stream #(.FE_TYPE(fe_t), .CTL_BITS(C), .OVR_WRT_BIT(OVR)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mul_fe2_if_dat(in_dat), .i_mul_fe2_if_val(in_val), .i_mul_fe2_if_sop(in_sop),
        .i_mul_fe2_if_eop(in_eop), .i_mul_fe2_if_err(in_err), .i_mul_fe2_if_ctl(in_ctl),
        .i_mul_fe2_if_rdy(in_rdy),
        .o_mul_fe2_if_dat(out_dat), .o_mul_fe2_if_val(out_val), .o_mul_fe2_if_sop(out_sop),
        .o_mul_fe2_if_eop(out_eop), .o_mul_fe2_if_err(out_err), .o_mul_fe2_if_ctl(out_ctl),
        .o_mul_fe2_if_rdy(out_rdy),
        .o_mul_fe_if_dat(mq_dat), .o_mul_fe_if_val(mq_val), .o_mul_fe_if_sop(mq_sop),
        .o_mul_fe_if_eop(mq_eop), .o_mul_fe_if_err(mq_err), .o_mul_fe_if_ctl(mq_ctl),
        .o_mul_fe_if_rdy(mq_rdy),
        .i_mul_fe_if_dat(mr_dat), .i_mul_fe_if_val(mr_val), .i_mul_fe_if_sop(1'b1),
        .i_mul_fe_if_eop(1'b1), .i_mul_fe_if_err(1'b0), .i_mul_fe_if_ctl(mr_ctl),
        .i_mul_fe_if_rdy(mr_rdy),
        .o_add_fe_if_dat(aq_dat), .o_add_fe_if_val(aq_val), .o_add_fe_if_sop(aq_sop),
        .o_add_fe_if_eop(aq_eop), .o_add_fe_if_err(aq_err), .o_add_fe_if_ctl(aq_ctl),
        .o_add_fe_if_rdy(aq_rdy),
        .i_add_fe_if_dat(ar_dat), .i_add_fe_if_val(ar_val), .i_add_fe_if_sop(1'b1),
        .i_add_fe_if_eop(1'b1), .i_add_fe_if_err(1'b0), .i_add_fe_if_ctl(ar_ctl),
        .i_add_fe_if_rdy(ar_rdy),
        .o_sub_fe_if_dat(sq_dat), .o_sub_fe_if_val(sq_val), .o_sub_fe_if_sop(sq_sop),
        .o_sub_fe_if_eop(sq_eop), .o_sub_fe_if_err(sq_err), .o_sub_fe_if_ctl(sq_ctl),
        .o_sub_fe_if_rdy(sq_rdy),
        .i_sub_fe_if_dat(sr_dat), .i_sub_fe_if_val(sr_val), .i_sub_fe_if_sop(1'b1),
        .i_sub_fe_if_eop(1'b1), .i_sub_fe_if_err(1'b0), .i_sub_fe_if_ctl(sr_ctl),
        .i_sub_fe_if_rdy(sr_rdy)
    );

    int n_chk = 0;
    int n_err = 0;

    beat_t in_q[$];
    exp_t  exp_q[$];
    pend_t mul_q[$];
    pend_t add_q[$];
    pend_t sub_q[$];

    int cyc = 0;
    int lat_min = 1, lat_max = 3;
    bit ooo_mode = 0, bp_mode = 0, blk_cfg = 0;
    int ooo_order[4] = '{3, 1, 0, 2};
    int ooo_idx = 0, ooo_next = 0;
    int mul_block = 0;
    int mul_sel;
    bit busy = 0, in_phase = 0, rdy_next = 0, mul_issued_any = 0, model_err = 0;
    int issue_idx = 0, mul_ret = 0;
    beat_t bt;
    exp_t  ex;
    pend_t pd;

    task automatic chk(input string name, input logic [767:0] act, input logic [767:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Mock Fp units
    function automatic fe_t fmul(input fe_t a, input fe_t b);
        logic [2*F-1:0] p;
        p = {{F{1'b0}}, a} * {{F{1'b0}}, b};
        p = p % {{F{1'b0}}, P};
        return p[F-1:0];
    endfunction

    function automatic fe_t fadd(input fe_t a, input fe_t b);
        logic [F:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[F-1:0];
    endfunction

    function automatic fe_t fsub(input fe_t a, input fe_t b);
        if (a >= b) return a - b;
        return P - b + a;
    endfunction

    // Fp2 reference: whole-number arithmetic then a single reduction
    function automatic fe_t ref_c0(input fe_t a0, input fe_t a1, input fe_t b0, input fe_t b1);
        logic [767:0] x, pp;
        pp = {387'b0, P} * {387'b0, P};
        x  = {387'b0, a0} * {387'b0, b0} + pp - {387'b0, a1} * {387'b0, b1};
        x  = x % {387'b0, P};
        return x[F-1:0];
    endfunction

    function automatic fe_t ref_c1(input fe_t a0, input fe_t a1, input fe_t b0, input fe_t b1);
        logic [767:0] x;
        x = {387'b0, a0} * {387'b0, b1} + {387'b0, a1} * {387'b0, b0};
        x = x % {387'b0, P};
        return x[F-1:0];
    endfunction

    function automatic fe_t rand_fe();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        if (r[F-1:0] >= P) return r[F-1:0] - P;
        return r[F-1:0];
    endfunction

    task automatic push_op(input fe_t a0, input fe_t a1, input fe_t b0, input fe_t b1, input logic [C-1:0] ctl);
        beat_t b;
        b.dat = {b0, a0}; b.sop = 1'b1; b.eop = 1'b0; b.ctl = ctl; in_q.push_back(b);
        b.dat = {b1, a1}; b.sop = 1'b0; b.eop = 1'b1; b.ctl = ctl; in_q.push_back(b);
    endtask

    task automatic push_exp(input fe_t c0, input fe_t c1, input logic [C-1:0] ctl);
        exp_t e;
        e.dat = c0; e.sop = 1'b1; e.eop = 1'b0; e.err = model_err; e.ctl = ctl; exp_q.push_back(e);
        e.dat = c1; e.sop = 1'b0; e.eop = 1'b1; e.err = model_err; e.ctl = ctl; exp_q.push_back(e);
    endtask

    task automatic push_model(input fe_t a0, input fe_t a1, input fe_t b0, input fe_t b1, input logic [C-1:0] ctl);
        push_op(a0, a1, b0, b1, ctl);
        push_exp(ref_c0(a0, a1, b0, b1), ref_c1(a0, a1, b0, b1), ctl);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #2;
            if (in_q.size() == 0 && exp_q.size() == 0 && !busy) done = 1;
        end
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: %0d beats still expected, required 0", name, exp_q.size());
            in_q.delete(); exp_q.delete();
        end
    endtask

    // Per-cycle mock units, input driver, output sink and compare process
    always @(negedge clk) begin
        cyc++;
        if (in_q.size() > 0) begin
            in_val = 1'b1; in_dat = in_q[0].dat; in_sop = in_q[0].sop; in_eop = in_q[0].eop; in_ctl = in_q[0].ctl;
        end else begin
            in_val = 1'b0; in_dat = '0; in_sop = 1'b0; in_eop = 1'b0; in_ctl = '0;
        end
        mul_sel = -1;
        for (int i = 0; i < mul_q.size(); i++) begin
            if (mul_sel < 0) begin
                if (ooo_mode) begin
                    if (ooo_idx < 4 && cyc >= ooo_next && int'(mul_q[i].ctl[OVR +: 2]) == ooo_order[ooo_idx]) mul_sel = i;
                end else if (mul_q[i].rdy_cyc <= cyc) begin
                    mul_sel = i;
                end
            end
        end
        if (mul_sel >= 0) begin
            mr_val = 1'b1; mr_dat = mul_q[mul_sel].res; mr_ctl = mul_q[mul_sel].ctl;
        end else begin
            mr_val = 1'b0; mr_dat = '0; mr_ctl = '0;
        end
        sr_val = (sub_q.size() > 0) && (sub_q[0].rdy_cyc <= cyc);
        sr_dat = sr_val ? sub_q[0].res : '0;
        sr_ctl = sr_val ? sub_q[0].ctl : '0;
        ar_val = (add_q.size() > 0) && (add_q[0].rdy_cyc <= cyc);
        ar_dat = ar_val ? add_q[0].res : '0;
        ar_ctl = ar_val ? add_q[0].ctl : '0;
        out_rdy = bp_mode ? cyc[0] : 1'b1;
        mq_rdy  = (mul_block == 0);
        if (mul_block > 0) mul_block--;
        aq_rdy = 1'b1;
        sq_rdy = 1'b1;
        #1;
        if (rst) begin
            chk("rst_in_rdy", in_rdy, 0);
            chk("rst_out_val", out_val, 0);
            chk("rst_mul_val", mq_val, 0);
            chk("rst_out_dat", out_dat, 0);
            busy = 0; in_phase = 0; issue_idx = 0; rdy_next = 0;
        end else begin
            if (rdy_next) begin
                chk("in_rdy_after_out", in_rdy, 1);
                rdy_next = 0;
            end
            if (in_val && in_rdy) begin
                bt = in_q.pop_front();
                if (!in_phase) begin
                    if (bt.sop) begin
                        in_phase = 1; issue_idx = 0; mul_ret = 0; ooo_idx = 0; ooo_next = cyc + 2;
                    end
                end else begin
                    in_phase = 0; busy = 1;
                    if (blk_cfg) mul_block = 5;
                end
            end else if (busy) begin
                chk("in_rdy_busy", in_rdy, 0);
            end
            if (mq_val && mq_rdy) begin
                chk("mul_tag_order", mq_ctl[OVR +: 2], issue_idx);
                pd.res = fmul(mq_dat[F-1:0], mq_dat[2*F-1:F]);
                pd.ctl = mq_ctl;
                pd.rdy_cyc = cyc + int'($urandom_range(lat_max, lat_min));
                mul_q.push_back(pd);
                issue_idx++;
                mul_issued_any = 1;
            end
            if (mul_sel >= 0 && mr_rdy) begin
                mul_q.delete(mul_sel);
                mul_ret++;
                if (ooo_mode) begin
                    ooo_idx++;
                    ooo_next = cyc + int'($urandom_range(4, 1));
                end
            end
            if (sq_val && sq_rdy) begin
                chk("addsub_after_last_tag", mul_ret, 4);
                chk("add_with_sub", aq_val, 1);
                pd.res = fsub(sq_dat[F-1:0], sq_dat[2*F-1:F]);
                pd.ctl = sq_ctl;
                pd.rdy_cyc = cyc + int'($urandom_range(3, 1));
                sub_q.push_back(pd);
            end
            if (aq_val && aq_rdy) begin
                pd.res = fadd(aq_dat[F-1:0], aq_dat[2*F-1:F]);
                pd.ctl = aq_ctl;
                pd.rdy_cyc = cyc + int'($urandom_range(3, 1));
                add_q.push_back(pd);
            end
            if (sr_val && sr_rdy) void'(sub_q.pop_front());
            if (ar_val && ar_rdy) void'(add_q.pop_front());
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL out_extra_beat: got beat %h, required no beat", out_dat);
                end else begin
                    ex = exp_q.pop_front();
                    chk("out_dat", out_dat, {{F{1'b0}}, ex.dat});
                    chk("out_sop", out_sop, ex.sop);
                    chk("out_eop", out_eop, ex.eop);
                    chk("out_ctl", out_ctl, ex.ctl);
                    chk("out_err", out_err, ex.err);
                end
                if (out_eop) begin
                    busy = 0;
                    rdy_next = 1;
                end
            end
        end
    end

    initial begin
        bit ok;
        fe_t m1;
        in_val = 0; in_dat = '0; in_sop = 0; in_eop = 0; in_err = 0; in_ctl = '0;
        out_rdy = 0; mq_rdy = 0; aq_rdy = 0; sq_rdy = 0;
        mr_val = 0; mr_dat = '0; mr_ctl = '0;
        ar_val = 0; ar_dat = '0; ar_ctl = '0;
        sr_val = 0; sr_dat = '0; sr_ctl = '0;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;

        // Single op with hand-computed result
        push_op(381'd3, 381'd5, 381'd7, 381'd11, 16'h00A5);
        push_exp(P - 381'd34, 381'd68, 16'h00A5);
        wait_done("single", 200);

        // Multiplier results returned as tags 3,1,0,2
        ooo_mode = 1;
        push_op(381'd3, 381'd5, 381'd7, 381'd11, 16'h00A5);
        push_exp(P - 381'd34, 381'd68, 16'h00A5);
        wait_done("out_of_order", 300);
        ooo_mode = 0;

        // Output backpressure and a stalled multiplier; includes the (-1,-1)^2 boundary
        bp_mode = 1; blk_cfg = 1;
        m1 = P - 381'd1;
        push_op(m1, m1, m1, m1, 16'hBEEF);
        push_exp(381'd0, 381'd2, 16'hBEEF);
        push_model(rand_fe(), rand_fe(), rand_fe(), rand_fe(), 16'h1357);
        wait_done("backpressure", 400);
        bp_mode = 0; blk_cfg = 0;

        // Stray non-sop beat, then a valid op carrying the sticky error
        bt.dat = {2*F{1'b1}}; bt.sop = 1'b0; bt.eop = 1'b0; bt.ctl = 16'h0F0F;
        in_q.push_back(bt);
        model_err = 1;
        push_op(381'd1, 381'd0, 381'd0, 381'd1, 16'h1234);
        push_exp(381'd0, 381'd1, 16'h1234);
        wait_done("proto_err", 300);

        // Reset while multiplies are outstanding, stale results, then a fresh op
        lat_min = 10; lat_max = 12;
        mul_issued_any = 0;
        push_op(381'd9, 381'd9, 381'd9, 381'd9, 16'h0099);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #2;
            if (mul_issued_any) ok = 1;
        end
        chk("reached_mul", ok, 1);
        @(negedge clk);
        rst = 1;
        exp_q.delete();
        in_q.delete();
        model_err = 0;
        @(negedge clk);
        rst = 0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk); #2;
            if (mul_q.size() == 0) ok = 1;
        end
        chk("stale_drained", ok, 1);
        lat_min = 1; lat_max = 3;
        push_op(381'd2, 381'd0, 381'd4, 381'd0, 16'h0042);
        push_exp(381'd8, 381'd0, 16'h0042);
        wait_done("after_reset", 300);

        // Back-to-back random operands against the reference model
        for (int k = 0; k < 100; k++) begin
            push_model(rand_fe(), rand_fe(), rand_fe(), rand_fe(), 16'($urandom));
        end
        wait_done("back_to_back", 6000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
